// File: rtl/seq_acc_pkg.sv
// Shared types for the framed sequence accumulator.
//   state_t : control FSM states
//   op_t    : per-operand arithmetic selection
package seq_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

endpackage

// File: rtl/sat_addsub.sv
// Combinational WIDTH+1-bit add/subtract with optional clamping.
//   x, y : unsigned operands (r = x + y or x - y)
//   op   : 0 = add, 1 = subtract
//   r    : WIDTH-bit result (wrapped, or clamped when SATURATE=1)
//   ovf  : carry out on add, borrow out on subtract
module sat_addsub
  import seq_acc_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter bit          SATURATE = 1'b0
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             op,
  output logic [WIDTH-1:0] r,
  output logic             ovf
);

  logic [WIDTH:0] ext;

  // Bit WIDTH of the extended result is the carry/borrow.
  always_comb begin
    if (op_t'(op) == OP_SUB) begin
      ext = {1'b0, x} - {1'b0, y};
    end else begin
      ext = {1'b0, x} + {1'b0, y};
    end
    ovf = ext[WIDTH];
    r   = ext[WIDTH-1:0];
    if (SATURATE && ovf) begin
      r = (op_t'(op) == OP_SUB) ? '0 : '1;
    end
  end

endmodule

// File: rtl/seq_accumulator.sv
// Framed running-sum accumulator with valid/ready operand input.
//   clk, reset(active-low async)
//   start/len : begin a sequence of len operands (sampled in IDLE)
//   clr       : synchronous abort to IDLE, q cleared
//   in_valid/in_ready/a/op : operand handshake
//   q, count, busy, done, overflow : registered status/result
module seq_accumulator
  import seq_acc_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned LEN_W    = 4,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic             op,
  output logic [WIDTH-1:0] q,
  output logic [LEN_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  state_t           state, state_n;
  logic [LEN_W-1:0] len_q, len_n;
  logic [WIDTH-1:0] q_n;
  logic [LEN_W-1:0] count_n;
  logic             ovf_n;
  logic             done_n, busy_n, ready_n;
  logic [WIDTH-1:0] sum_c;
  logic             sum_ovf_c;
  logic             last_c;

  sat_addsub #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_addsub (
    .x   (q),
    .y   (a),
    .op  (op),
    .r   (sum_c),
    .ovf (sum_ovf_c)
  );

  // ACCUM is only entered with len_q >= 1, so len_q-1 never underflows there.
  assign last_c = (count == LEN_W'(len_q - LEN_W'(1)));

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      len_q    <= '0;
      q        <= '0;
      count    <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      state    <= state_n;
      len_q    <= len_n;
      q        <= q_n;
      count    <= count_n;
      overflow <= ovf_n;
      done     <= done_n;
      busy     <= busy_n;
      in_ready <= ready_n;
    end
  end

  // Next-state and next-output logic; clr overrides everything.
  always_comb begin
    state_n = state;
    len_n   = len_q;
    q_n     = q;
    count_n = count;
    ovf_n   = overflow;

    unique case (state)
      IDLE: begin
        if (start) begin
          q_n     = '0;
          count_n = '0;
          ovf_n   = 1'b0;
          len_n   = len;
          state_n = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          q_n     = sum_c;
          count_n = LEN_W'(count + LEN_W'(1));
          ovf_n   = overflow | sum_ovf_c;
          if (last_c) begin
            state_n = DONE;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (clr) begin
      state_n = IDLE;
      q_n     = '0;
      count_n = '0;
      ovf_n   = 1'b0;
    end

    // Status flags are registered copies of the upcoming state.
    done_n  = (state_n == DONE);
    busy_n  = (state_n == ACCUM);
    ready_n = (state_n == ACCUM);
  end

endmodule
